// File: rtl/hazard_ctrl_if.sv
// Syscall request/acknowledge channel between hazard_ctrl (master) and the
// syscall responder (slave); four-phase req/ack with latched code and argument.
interface hazard_ctrl_if #(
  parameter int unsigned CODE_W = 32
);
  logic              syscall_req;
  logic [CODE_W-1:0] syscall_code;
  logic [CODE_W-1:0] syscall_arg;
  logic              syscall_ack;

  modport master (
    output syscall_req,
    output syscall_code,
    output syscall_arg,
    input  syscall_ack
  );

  modport slave (
    input  syscall_req,
    input  syscall_code,
    input  syscall_arg,
    output syscall_ack
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard detection, forwarding selects and syscall hold/halt FSM for the 5-stage MIPS pipeline.
// Optional HAZARD_PERF_EN adds stall/flush cycle counters. State updates on negedge clk.
module hazard_ctrl #(
  parameter int unsigned EXIT_CODE      = 10,
  parameter int unsigned SYSCALL_CODE_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  WriteRegM,
  input  logic [4:0]  WriteRegW,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        RegWriteW,
  input  logic        BranchD,
  input  logic        SyscallE,
  input  logic [31:0] v0E,
  input  logic [31:0] a0E,
  hazard_ctrl_if.master sys,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushE,
  output logic        ForwardAD,
  output logic        ForwardBD,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
`ifdef HAZARD_PERF_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles,
`endif
  output logic        halted
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_HALT} state_t;

  state_t                    state_q, state_d;
  logic [SYSCALL_CODE_W-1:0] code_q, code_d;
  logic [SYSCALL_CODE_W-1:0] arg_q, arg_d;
  logic                      lwstall, branchstall, busy, hold;
  logic                      req, halt;

  // Hazard detection and forwarding (purely combinational)
  always_comb begin
    lwstall     = MemtoRegE && ((RsD == RtE) || (RtD == RtE));
    branchstall = BranchD &&
                  ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                   (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));
    busy        = (state_q != S_IDLE);
    hold        = lwstall || branchstall || busy;
    StallF      = hold;
    StallD      = hold;
    FlushE      = hold;

    ForwardAD = (RsD != '0) && (RsD == WriteRegM) && RegWriteM;
    ForwardBD = (RtD != '0) && (RtD == WriteRegM) && RegWriteM;

    if ((RsE != '0) && (RsE == WriteRegM) && RegWriteM)      ForwardAE = 2'b10;
    else if ((RsE != '0) && (RsE == WriteRegW) && RegWriteW) ForwardAE = 2'b01;
    else                                                     ForwardAE = 2'b00;

    if ((RtE != '0) && (RtE == WriteRegM) && RegWriteM)      ForwardBE = 2'b10;
    else if ((RtE != '0) && (RtE == WriteRegW) && RegWriteW) ForwardBE = 2'b01;
    else                                                     ForwardBE = 2'b00;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      arg_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      arg_q   <= arg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    arg_d   = arg_q;
    unique case (state_q)
      S_IDLE: if (SyscallE) begin
        code_d  = v0E[SYSCALL_CODE_W-1:0];
        arg_d   = a0E[SYSCALL_CODE_W-1:0];
        state_d = (v0E == EXIT_CODE) ? S_HALT : S_REQ;
      end
      S_REQ:  if (sys.syscall_ack)  state_d = S_DONE;
      S_DONE: if (!sys.syscall_ack) state_d = S_IDLE;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Decoded from state so reset drops req/halted without waiting for a clock
  always_comb begin
    req  = (state_q == S_REQ);
    halt = (state_q == S_HALT);
  end

  assign sys.syscall_req  = req;
  assign sys.syscall_code = code_q;
  assign sys.syscall_arg  = arg_q;
  assign halted           = halt;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, StallF};
    flush_cnt_d = flush_cnt_q + {31'd0, FlushE};
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and syscall-hold controller; it is the producer end of the execute-register `clr` line. It computes the stall, flush and forwarding selects for the 5-stage MIPS pipeline, including the `clr` that empties the ID/EX register. A small FSM on the same edge as the pipeline registers freezes fetch/decode and bubbles execute while a syscall request is serviced. It also halts the machine on the exit syscall.

## Interface
- `EXIT_CODE`, default 10: `v0` value that halts the pipeline.
- `SYSCALL_CODE_W`, default 32: width of latched `v0`/`a0`.
- `clk` in 1: pipeline clock; state updates on its falling edge.
- `rst` in 1: reset, asynchronous, active-high.
- `RsD`, `RtD` in 5 each: decode-stage source registers.
- `RsE`, `RtE` in 5 each: execute-stage source registers, from `reg_e`.
- `WriteRegE`, `WriteRegM`, `WriteRegW` in 5 each: destination register per stage.
- `RegWriteE`, `MemtoRegE` in 1 each: `reg_e` `hazard_in_RegWriteE` / `hazard_in_MemtoRegE`.
- `RegWriteM`, `MemtoRegM`, `RegWriteW` in 1 each: later-stage controls.
- `BranchD` in 1: decode-stage branch.
- `SyscallE` in 1: syscall in execute.
- `v0E`, `a0E` in 32 each: register values accompanying the syscall.
- `syscall_ack` in 1: service-complete, level, from the syscall responder.
- `StallF`, `StallD` out 1 each: hold PC and the IF/ID register.
- `FlushE` out 1: drives `reg_e` `clr`.
- `ForwardAD`, `ForwardBD` out 1 each: decode-compare forward from M.
- `ForwardAE`, `ForwardBE` out 2 each: 00 regfile, 01 from W, 10 from M.
- `syscall_req` out 1, `syscall_code` out 32, `syscall_arg` out 32: request to the responder.
- `halted` out 1: exit syscall taken.

## Operation
- Forwarding is combinational. ForwardAE=10 if RsE≠0, RsE==WriteRegM and RegWriteM. Else it is 01 if RsE≠0, RsE==WriteRegW and RegWriteW. Else 00. M has priority over W. ForwardBE follows the same rule using RtE.
- ForwardAD=1 when RsD≠0, RsD==WriteRegM and RegWriteM. ForwardBD follows the same rule using RtD.
- lwstall = MemtoRegE and (RsD==RtE or RtD==RtE).
- branchstall = BranchD and either of:
  - RegWriteE with WriteRegE ∈ {RsD, RtD};
  - MemtoRegM with WriteRegM ∈ {RsD, RtD}.
- busy = state≠IDLE.
- StallF = StallD = FlushE = lwstall | branchstall | busy.
- FSM states:
  - IDLE: if SyscallE is high, latch v0E→syscall_code and a0E→syscall_arg. If v0E==EXIT_CODE go to HALT, else go to REQ.
  - REQ: syscall_req=1. When syscall_ack is sampled high, go to DONE.
  - DONE: syscall_req=0. Wait until syscall_ack is low, then go to IDLE. This gives a four-phase handshake.
  - HALT: halted=1. No exit except rst.
- syscall_code and syscall_arg hold their values from the latch edge until the next latch.

## Timing
- All state, syscall_code and syscall_arg update on negedge clk, the same edge as `reg_e`.
- Reset values: state=IDLE; syscall_req=0, syscall_code=0, syscall_arg=0, halted=0. Combinational outputs then follow their equations with busy=0.
- SyscallE high before negedge n: syscall_req and stalls are asserted after edge n. The syscall instruction itself proceeds to M; subsequent E slots are bubbles.
- syscall_ack is level-sampled at negedge. The minimum busy period is 2 edges (REQ→DONE→IDLE). Stalls release after the edge on which DONE sees ack low.
- syscall_ack high while in IDLE or HALT is ignored.
- SyscallE is ignored while busy; it cannot occur because E is flushed.
- lwstall and branchstall in the same cycle: outputs are the OR of both; no priority is needed.
- rst asserted during REQ, DONE or HALT: immediate return to IDLE, with syscall_req and halted dropping asynchronously.

## Configuration
- `HAZARD_PERF_EN` defined: adds outputs `stall_cycles` out 32 and `flush_cycles` out 32. They count negedges with StallF=1 and FlushE=1 respectively, are reset to 0, and wrap at 2^32.
- `HAZARD_PERF_EN` undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Load-use: MemtoRegE=1, RtE=8, RsD=8 → StallF=StallD=FlushE=1 for exactly one cycle. Then RsE=8, WriteRegW=8, RegWriteW=1 → ForwardAE=01.
- Double hit: RsE=9, WriteRegM=9, RegWriteM=1, WriteRegW=9, RegWriteW=1 → ForwardAE=10. RsE=0 with matching writes → 00.
- Branch: BranchD=1, RsD=4, RegWriteE=1, WriteRegE=4 → stall asserted. MemtoRegM case (WriteRegM=4) → stall asserted.
- Syscall, ack after 3 edges:
  - SyscallE=1, v0E=1, a0E=0x2A → syscall_req=1, code=1, arg=0x2A.
  - Stalls are held until ack is seen, and release one edge after ack drops.
- Exit: v0E=10 → halted=1, stalls held for 20 cycles. rst pulse mid-halt → halted=0, stalls low immediately.
- With `HAZARD_PERF_EN`: run a single load-use stall plus a syscall with 3-edge ack → stall_cycles=6 (1 load-use + 3 REQ + 2 DONE), flush_cycles=6.
